// File: rtl/wb_sdram_mport.sv
// Multi-port Wishbone B4 pipelined front end for a single sdram_controller request port.
// Arbitrates NP masters (fixed priority or round-robin) with optional cycle locking and a burst cap.
module wb_sdram_mport #(
  parameter int NP        = 4,
  parameter int AW        = 24,
  parameter int DW        = 16,
  parameter int ARB_MODE  = 1,
  parameter int LOCK_CYC  = 1,
  parameter int MAX_BURST = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NP-1:0]        wb_cyc_i,
  input  logic [NP-1:0]        wb_stb_i,
  input  logic [NP-1:0]        wb_we_i,
  input  logic [NP*AW-1:0]     wb_adr_i,
  input  logic [NP*DW-1:0]     wb_dat_i,
  input  logic [NP*DW/8-1:0]   wb_sel_i,
  output logic [NP-1:0]        wb_ack_o,
  output logic [NP-1:0]        wb_stall_o,
  output logic [DW-1:0]        wb_dat_o,
  output logic                 bus_req_valid,
  output logic                 bus_req_write,
  output logic [AW-1:0]        bus_req_addr,
  output logic [DW-1:0]        bus_req_wdata,
  output logic [DW/8-1:0]      bus_req_byteenable,
  input  logic                 bus_req_ready,
  input  logic                 bus_rsp_early_valid,
  input  logic                 bus_rsp_valid,
  input  logic [DW-1:0]        bus_rsp_rdata
);

  localparam int IW = (NP > 1) ? $clog2(NP) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam int SW = DW / 8;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   gnt_idx_q, gnt_idx_d;
  logic [IW-1:0]   ack_idx_q, ack_idx_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ack_vld_q, ack_vld_d;

  logic [NP-1:0]   req;
  logic [NP-1:0]   gnt_oh;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand_idx;
  logic            win_found;
  int              cand;
  logic            g_cyc, g_stb, g_we;
  logic            accept, other_req;
  logic [CW-1:0]   cnt_inc;
  logic            cap_hit;

  assign req = wb_cyc_i & wb_stb_i;

  // Scan starts at port 0 (fixed) or at rr_ptr (round-robin); first requester wins.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < NP; i++) begin
      cand     = (ARB_MODE == 0) ? i : (int'(rr_ptr_q) + i) % NP;
      cand_idx = IW'(cand);
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  assign g_cyc = wb_cyc_i[gnt_idx_q];
  assign g_stb = wb_stb_i[gnt_idx_q];
  assign g_we  = wb_we_i[gnt_idx_q];

  assign bus_req_valid      = (state_q == GRANT) & g_cyc & g_stb;
  assign bus_req_write      = g_we;
  assign bus_req_addr       = wb_adr_i[gnt_idx_q*AW +: AW];
  assign bus_req_wdata      = wb_dat_i[gnt_idx_q*DW +: DW];
  assign bus_req_byteenable = wb_sel_i[gnt_idx_q*SW +: SW];
  assign wb_dat_o           = bus_rsp_rdata;

  // Reads complete on early_valid; bus_rsp_valid is not needed by this front end.
  assign accept = bus_req_valid & (g_we ? bus_req_ready : bus_rsp_early_valid);

  always_comb begin
    gnt_oh            = '0;
    gnt_oh[gnt_idx_q] = 1'b1;
  end

  assign other_req = |(req & ~gnt_oh);
  assign cnt_inc   = (cnt_q == CW'(MAX_BURST)) ? cnt_q : cnt_q + 1'b1;
  assign cap_hit   = accept && (cnt_inc == CW'(MAX_BURST)) && other_req;

  always_comb begin
    wb_stall_o = wb_stb_i;
    if (state_q == GRANT)
      wb_stall_o[gnt_idx_q] = (g_we & ~bus_req_ready) | (~g_we & ~bus_rsp_early_valid);
  end

  always_comb begin
    wb_ack_o            = '0;
    wb_ack_o[ack_idx_q] = ack_vld_q;
  end

  always_comb begin
    state_d   = state_q;
    gnt_idx_d = gnt_idx_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    ack_vld_d = accept;
    ack_idx_d = accept ? gnt_idx_q : ack_idx_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d   = GRANT;
          gnt_idx_d = win_idx;
          cnt_d     = '0;
          rr_ptr_d  = (win_idx == IW'(NP - 1)) ? '0 : win_idx + 1'b1;
        end
      end
      GRANT: begin
        if (LOCK_CYC == 0) begin
          // Also release if the master abandons the cycle before acceptance.
          if (accept || !g_cyc) state_d = IDLE;
        end else begin
          if (accept) cnt_d = cnt_inc;
          if (!g_cyc || cap_hit) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_idx_q <= '0;
      ack_idx_q <= '0;
      rr_ptr_q  <= '0;
      cnt_q     <= '0;
      ack_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_idx_q <= gnt_idx_d;
      ack_idx_q <= ack_idx_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
      ack_vld_q <= ack_vld_d;
    end
  end

endmodule

// File: tb/tb_wb_sdram_mport.sv
// Bench for wb_sdram_mport: three configurations share stimulus; a scoreboard of expected acks
// is checked against the selected instance.
module tb_wb_sdram_mport;

  localparam int NP = 4;
  localparam int AW = 24;
  localparam int DW = 16;
  localparam int ARB_T[3]  = '{1, 1, 0};
  localparam int LOCK_T[3] = '{1, 0, 0};
  localparam int MAXB_T[3] = '{4, 16, 16};

  typedef struct {
    int          port;
    bit          rd;
    logic [15:0] dat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NP-1:0]      cyc, stb, we;
  logic [NP*AW-1:0]   adr;
  logic [NP*DW-1:0]   dat;
  logic [NP*DW/8-1:0] sel_b;
  logic               ready, early, rsp_valid;
  logic [DW-1:0]      rdata;

  logic [NP-1:0]   ack_o   [3];
  logic [NP-1:0]   stall_o [3];
  logic [DW-1:0]   dat_o   [3];
  logic            valid_o [3];
  logic            write_o [3];
  logic [AW-1:0]   addr_o  [3];
  logic [DW-1:0]   wdata_o [3];
  logic [DW/8-1:0] be_o    [3];

  int sel = 0;
  logic [NP-1:0] ack_s, stall_s;
  logic [DW-1:0] dat_s, wdata_s;
  logic [AW-1:0] addr_s;
  logic          valid_s, write_s;
  logic [1:0]    be_s;

  int   total = 0;
  int   bad   = 0;
  int   cyc_cnt = 0;
  int   n [NP];
  exp_t exp_q [$];
  int   ack_t [$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    wb_sdram_mport #(
      .NP(NP), .AW(AW), .DW(DW),
      .ARB_MODE(ARB_T[gi]), .LOCK_CYC(LOCK_T[gi]), .MAX_BURST(MAXB_T[gi])
    ) u_dut (
      .clk                 (clk),
      .rst                 (rst),
      .wb_cyc_i            (cyc),
      .wb_stb_i            (stb),
      .wb_we_i             (we),
      .wb_adr_i            (adr),
      .wb_dat_i            (dat),
      .wb_sel_i            (sel_b),
      .wb_ack_o            (ack_o[gi]),
      .wb_stall_o          (stall_o[gi]),
      .wb_dat_o            (dat_o[gi]),
      .bus_req_valid       (valid_o[gi]),
      .bus_req_write       (write_o[gi]),
      .bus_req_addr        (addr_o[gi]),
      .bus_req_wdata       (wdata_o[gi]),
      .bus_req_byteenable  (be_o[gi]),
      .bus_req_ready       (ready),
      .bus_rsp_early_valid (early),
      .bus_rsp_valid       (rsp_valid),
      .bus_rsp_rdata       (rdata)
    );
  end

  assign ack_s   = ack_o[sel];
  assign stall_s = stall_o[sel];
  assign dat_s   = dat_o[sel];
  assign valid_s = valid_o[sel];
  assign write_s = write_o[sel];
  assign addr_s  = addr_o[sel];
  assign wdata_s = wdata_o[sel];
  assign be_s    = be_o[sel];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic push_exp(input int p, input bit rd, input logic [15:0] d);
    exp_t e;
    e.port = p; e.rd = rd; e.dat = d;
    exp_q.push_back(e);
  endtask

  // Every ack on the selected instance must match the head of the scoreboard.
  always @(negedge clk) begin
    if (ack_s != '0) begin
      ack_t.push_back(cyc_cnt);
      if (exp_q.size() == 0) begin
        chk("unexp_ack", 32'(ack_s), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ack_port", 32'(ack_s), 32'(4'b0001 << mon_e.port));
        if (mon_e.rd) chk("rdata", 32'(dat_s), 32'(mon_e.dat));
      end
    end
  end

  task automatic clear_wb();
    cyc = '0; stb = '0; we = '0; adr = '0; dat = '0; sel_b = '1;
  endtask

  task automatic do_reset(input int which);
    sel   = which;
    rst   = 1'b1;
    clear_wb();
    stb   = 4'b1010;
    ready = 1'b1; early = 1'b1; rsp_valid = 1'b0; rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 32'(ack_s), 32'd0);
    chk("rst_valid", 32'(valid_s), 32'd0);
    chk("rst_stall", 32'(stall_s), 32'h0000000a);
    stb = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic bit busy();
    for (int p = 0; p < NP; p++) if (n[p] > 0) return 1'b1;
    return 1'b0;
  endfunction

  // Reactive masters: port p issues n[p] writes, retiring one whenever it is not stalled.
  task automatic run_master(input int lim);
    logic [NP-1:0] acc;
    int left;
    we = '1;
    for (int c = 0; c < lim && busy(); c++) begin
      for (int p = 0; p < NP; p++) begin
        cyc[p] = (n[p] > 0);
        stb[p] = (n[p] > 0);
        adr[p*AW +: AW] = AW'(p * 256 + n[p]);
        dat[p*DW +: DW] = DW'(p * 4369 ^ n[p]);
      end
      @(negedge clk);
      acc = stb & ~stall_s;
      for (int p = 0; p < NP; p++)
        if (acc[p]) chk("req_adr", 32'(addr_s), 32'(adr[p*AW +: AW]));
      @(posedge clk); #1;
      for (int p = 0; p < NP; p++) if (acc[p]) n[p]--;
    end
    cyc = '0; stb = '0;
    left = 0;
    for (int p = 0; p < NP; p++) left += n[p];
    chk("master_done", 32'(left), 32'd0);
  endtask

  task automatic drain();
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    clear_wb();
    ready = 1'b1; early = 1'b1; rsp_valid = 1'b0; rdata = '0;

    // Single write from port 2
    do_reset(0);
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1;
    adr[2*AW +: AW] = 24'h000010; dat[2*DW +: DW] = 16'hA5A5;
    push_exp(2, 1'b0, 16'h0);
    @(negedge clk);
    chk("wr_valid_c1", 32'(valid_s), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wr_valid_c2", 32'(valid_s), 32'd1);
    chk("wr_write", 32'(write_s), 32'd1);
    chk("wr_addr", 32'(addr_s), 32'h10);
    chk("wr_wdata", 32'(wdata_s), 32'hA5A5);
    chk("wr_be", 32'(be_s), 32'h3);
    chk("wr_stall", 32'(stall_s[2]), 32'd0);
    @(posedge clk); #1;
    clear_wb();
    @(negedge clk);
    chk("wr_ack_c3", 32'(ack_s), 32'h4);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wr_ack_c4", 32'(ack_s), 32'h0);
    drain();

    // Read from port 0 with delayed early_valid
    do_reset(0);
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0;
    adr[0 +: AW] = 24'h000020;
    early = 1'b0; rdata = 16'h1234;
    push_exp(0, 1'b1, 16'h1234);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rd_stall_wait", 32'(stall_s[0]), 32'd1);
      @(posedge clk); #1;
    end
    early = 1'b1;
    @(negedge clk);
    chk("rd_stall_go", 32'(stall_s[0]), 32'd0);
    chk("rd_addr", 32'(addr_s), 32'h20);
    @(posedge clk); #1;
    clear_wb();
    early = 1'b0;
    drain();
    early = 1'b1;

    // Round-robin, no locking
    do_reset(1);
    n = '{2, 2, 0, 2};
    push_exp(0, 0, 0); push_exp(1, 0, 0); push_exp(3, 0, 0);
    push_exp(0, 0, 0); push_exp(1, 0, 0); push_exp(3, 0, 0);
    run_master(100);
    drain();

    // Fixed priority, no locking
    do_reset(2);
    n = '{0, 3, 0, 2};
    push_exp(1, 0, 0); push_exp(1, 0, 0); push_exp(1, 0, 0);
    push_exp(3, 0, 0); push_exp(3, 0, 0);
    run_master(100);
    drain();

    // Burst cap of 4 under contention
    do_reset(0);
    n = '{6, 2, 0, 0};
    for (int k = 0; k < 4; k++) push_exp(0, 0, 0);
    push_exp(1, 0, 0); push_exp(1, 0, 0);
    push_exp(0, 0, 0); push_exp(0, 0, 0);
    run_master(100);
    drain();

    // Saturated counter keeps the grant when nobody else asks
    do_reset(0);
    ack_t.delete();
    n = '{7, 0, 0, 0};
    for (int k = 0; k < 7; k++) push_exp(0, 0, 0);
    run_master(100);
    drain();
    chk("sat_ack_count", 32'(ack_t.size()), 32'd7);
    if (ack_t.size() > 0)
      chk("sat_ack_span", 32'(ack_t[ack_t.size()-1] - ack_t[0]), 32'd6);

    // Reset during a stalled read
    do_reset(0);
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0;
    adr[0 +: AW] = 24'h000020;
    early = 1'b0; rdata = 16'h00BE;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ack", 32'(ack_s), 32'd0);
    chk("mid_rst_valid", 32'(valid_s), 32'd0);
    chk("mid_rst_stall", 32'(stall_s), 32'h1);
    @(posedge clk); #1;
    rst = 1'b0; early = 1'b1;
    push_exp(0, 1'b1, 16'h00BE);
    @(negedge clk);
    chk("post_rst_idle", 32'(valid_s), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_grant", 32'(valid_s), 32'd1);
    @(posedge clk); #1;
    clear_wb();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
